// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master round-robin arbiter in front of one valid/ready
// memory slave. Master 0 is instruction fetch, master 1 is load/store.
// Each transaction costs one IDLE arbitration cycle plus the BUSY cycles;
// a watchdog completes a stuck transaction with ERR_DATA and an err pulse.
module mem_arbiter #(
    parameter int unsigned TIMEOUT  = 256,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic        grant,
    output logic        busy,
    output logic        err
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    // Watchdog compare value; a zero TIMEOUT turns the watchdog off entirely.
    localparam bit          WD_EN   = (TIMEOUT != 0);
    localparam logic [15:0] WD_LAST = WD_EN ? 16'(TIMEOUT - 1) : 16'd0;

    state_t      state;
    logic        grant_q;
    logic        last_q;
    logic [15:0] wd_cnt;

    // Masters gathered into packed arrays so the slave mux is a plain index.
    logic [1:0]       m_valid;
    logic [1:0][31:0] m_addr;
    logic [1:0][31:0] m_wdata;
    logic [1:0][3:0]  m_wstrb;

    assign m_valid = {m1_valid, m0_valid};
    assign m_addr  = {m1_addr,  m0_addr};
    assign m_wdata = {m1_wdata, m0_wdata};
    assign m_wstrb = {m1_wstrb, m0_wstrb};

    logic in_busy;
    logic timeout_hit;
    logic done;
    logic winner;

    assign in_busy     = (state == BUSY);
    // A real s_ready in the last watchdog cycle wins over the timeout.
    assign timeout_hit = WD_EN && in_busy && !s_ready && (wd_cnt == WD_LAST);
    assign done        = in_busy && (s_ready || timeout_hit);
    // Lone requester wins; on contention the master that did not go last wins.
    assign winner      = m1_valid && (!m0_valid || !last_q);

    // Arbitration state, grant/last pointers and the watchdog counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            wd_cnt  <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (|m_valid) begin
                        grant_q <= winner;
                        state   <= BUSY;
                        wd_cnt  <= 16'd0;
                    end
                end
                BUSY: begin
                    if (done) begin
                        last_q <= grant_q;
                        state  <= IDLE;
                    end else if (wd_cnt != 16'hFFFF) begin
                        wd_cnt <= wd_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are forced quiet while rst is high so an aborted transaction
    // never produces a completion, even if s_ready lands in the reset cycle.
    assign busy    = in_busy && !rst;
    assign grant   = grant_q;
    assign err     = timeout_hit && !rst;
    assign s_valid = busy && m_valid[grant_q];
    assign s_addr  = m_addr[grant_q];
    assign s_wdata = m_wdata[grant_q];
    assign s_wstrb = m_wstrb[grant_q];

    assign m0_ready = done && !rst && !grant_q;
    assign m1_ready = done && !rst &&  grant_q;
    assign m0_rdata = (timeout_hit && !grant_q) ? ERR_DATA : s_rdata;
    assign m1_rdata = (timeout_hit &&  grant_q) ? ERR_DATA : s_rdata;

endmodule
